// File: rtl/tdc_arb_pkg.sv
// Shared constants and helpers for the TDC write arbiter.
// Holds the default data width, tag width derivation and the saturating adder.
package tdc_arb_pkg;

  localparam int unsigned DefaultDw = 64;

  function automatic int unsigned tag_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter widths up to 63 bits fit; the 65-bit sum cannot wrap.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] max);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[63:0];
  endfunction

endpackage

// File: rtl/tdc_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, with wrap.
// The request vector is duplicated so the wrap becomes a plain upward scan.
module rr_pick #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned TAG_W = 2
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [TAG_W-1:0] ptr_i,
  input  logic             en_i,
  output logic             gnt_valid_o,
  output logic [TAG_W-1:0] gnt_idx_o
);

  logic [2*N_CH-1:0] req2;

  always_comb begin
    req2        = {req_i, req_i};
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    // Scan downwards so the lowest qualifying position wins.
    for (int k = 2 * N_CH - 1; k >= 0; k--) begin
      if (en_i && req2[k] && (k >= int'(ptr_i)) && (k < int'(ptr_i) + int'(N_CH))) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = (k >= int'(N_CH)) ? TAG_W'(k - int'(N_CH)) : TAG_W'(k);
      end
    end
  end

endmodule

// File: rtl/tdc_write_arbiter.sv
// Shares one FIFO write port between N_CH TDC channels: per-channel holding
// registers, round-robin drain with channel tags, and drop accounting.
module tdc_write_arbiter
  import tdc_arb_pkg::*;
#(
  parameter int unsigned  N_CH  = 4,
  parameter int unsigned  DW    = DefaultDw,
  parameter int unsigned  CNT_W = 16,
  localparam int unsigned TAG_W = tag_w(N_CH)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N_CH-1:0]    ch_done_i,
  input  logic [N_CH*DW-1:0] ch_data_i,
  input  logic               fifo_full_i,
  input  logic               clr_drop_i,
  output logic               fifo_wr_o,
  output logic [DW-1:0]      fifo_din_o,
  output logic [TAG_W-1:0]   fifo_tag_o,
  output logic [N_CH-1:0]    ch_busy_o,
  output logic [N_CH-1:0]    drop_sticky_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  localparam logic [63:0] CntMax = (64'd1 << CNT_W) - 64'd1;

  logic [DW-1:0]    hold_q [N_CH];
  logic [DW-1:0]    hold_d [N_CH];
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic [DW-1:0]    fifo_din_q, fifo_din_d;
  logic [TAG_W-1:0] fifo_tag_q, fifo_tag_d;
  logic [N_CH-1:0]  sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             gnt_valid;
  logic [TAG_W-1:0] gnt_idx;
  logic [N_CH-1:0]  gnt_hit;
  logic [N_CH-1:0]  drop;
  logic [63:0]      n_drop;
  logic [63:0]      cnt_base;

  rr_pick #(
    .N_CH  (N_CH),
    .TAG_W (TAG_W)
  ) u_rr_pick (
    .req_i       (pend_q),
    .ptr_i       (rr_ptr_q),
    .en_i        (~fifo_full_i),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // A channel being drained this cycle frees its slot for a same-cycle capture.
  always_comb begin
    hold_d  = hold_q;
    pend_d  = pend_q;
    gnt_hit = '0;
    drop    = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      gnt_hit[i] = gnt_valid && (gnt_idx == TAG_W'(i));
      if (gnt_hit[i]) begin
        pend_d[i] = 1'b0;
      end
      if (ch_done_i[i]) begin
        if (!pend_q[i] || gnt_hit[i]) begin
          hold_d[i] = ch_data_i[i*DW +: DW];
          pend_d[i] = 1'b1;
        end else begin
          drop[i] = 1'b1;
        end
      end
    end
  end

  // Clear applies before this cycle's drops are accumulated.
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      n_drop = n_drop + 64'(drop[i]);
    end
    cnt_base = clr_drop_i ? '0 : 64'(cnt_q);
    cnt_d    = CNT_W'(sat_add(cnt_base, n_drop, CntMax));
    sticky_d = (clr_drop_i ? '0 : sticky_q) | drop;
  end

  always_comb begin
    fifo_wr_d  = gnt_valid;
    fifo_din_d = fifo_din_q;
    fifo_tag_d = fifo_tag_q;
    rr_ptr_d   = rr_ptr_q;
    if (gnt_valid) begin
      fifo_din_d = hold_q[gnt_idx];
      fifo_tag_d = gnt_idx;
      rr_ptr_d   = (gnt_idx == TAG_W'(N_CH - 1)) ? '0 : gnt_idx + TAG_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        hold_q[i] <= '0;
      end
      pend_q     <= '0;
      rr_ptr_q   <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_din_q <= '0;
      fifo_tag_q <= '0;
      sticky_q   <= '0;
      cnt_q      <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        hold_q[i] <= hold_d[i];
      end
      pend_q     <= pend_d;
      rr_ptr_q   <= rr_ptr_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_din_q <= fifo_din_d;
      fifo_tag_q <= fifo_tag_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fifo_wr_o     = fifo_wr_q;
  assign fifo_din_o    = fifo_din_q;
  assign fifo_tag_o    = fifo_tag_q;
  assign ch_busy_o     = pend_q;
  assign drop_sticky_o = sticky_q;
  assign drop_cnt_o    = cnt_q;

endmodule

// File: tb/tb_tdc_write_arbiter.sv
// Bench for tdc_write_arbiter (4 channels, 4-bit drop counter) against a
// cycle-level behavioural model of the capture/drain/drop rules.
module tb_tdc_write_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   ch_done;
  logic [255:0] ch_data;
  logic         fifo_full;
  logic         clr_drop;
  logic         fifo_wr;
  logic [63:0]  fifo_din;
  logic [1:0]   fifo_tag;
  logic [3:0]   ch_busy;
  logic [3:0]   drop_sticky;
  logic [3:0]   drop_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit          m_pend [4];
  logic [63:0] m_hold [4];
  int          m_ptr;
  bit          m_wr;
  logic [63:0] m_din;
  int          m_tag;
  int          m_cnt;
  logic [3:0]  m_sticky;

  tdc_write_arbiter #(
    .N_CH  (4),
    .DW    (64),
    .CNT_W (4)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .ch_done_i     (ch_done),
    .ch_data_i     (ch_data),
    .fifo_full_i   (fifo_full),
    .clr_drop_i    (clr_drop),
    .fifo_wr_o     (fifo_wr),
    .fifo_din_o    (fifo_din),
    .fifo_tag_o    (fifo_tag),
    .ch_busy_o     (ch_busy),
    .drop_sticky_o (drop_sticky),
    .drop_cnt_o    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rnd_bus();
    logic [255:0] b;
    for (int c = 0; c < 4; c++) b[c*64 +: 64] = {$urandom, $urandom};
    return b;
  endfunction

  function automatic logic [3:0] m_busy();
    logic [3:0] b;
    for (int c = 0; c < 4; c++) b[c] = m_pend[c];
    return b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_pend[c] = 1'b0;
      m_hold[c] = '0;
    end
    m_ptr = 0; m_wr = 1'b0; m_din = '0; m_tag = 0; m_cnt = 0; m_sticky = '0;
  endtask

  // One clock edge of the arbiter's rules, using the inputs currently driven.
  task automatic model_edge();
    int g;
    g = -1;
    if (!fifo_full) begin
      for (int o = 0; o < 4; o++) begin
        if (g < 0 && m_pend[(m_ptr + o) % 4]) g = (m_ptr + o) % 4;
      end
    end
    if (clr_drop) begin
      m_cnt = 0;
      m_sticky = '0;
    end
    if (g >= 0) begin
      m_wr = 1'b1; m_din = m_hold[g]; m_tag = g;
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % 4;
    end else begin
      m_wr = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      if (ch_done[c]) begin
        if (!m_pend[c]) begin
          m_hold[c] = ch_data[c*64 +: 64];
          m_pend[c] = 1'b1;
        end else begin
          m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
          m_sticky[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] done, input logic full, input logic clr,
                      input logic [255:0] data);
    ch_done = done; fifo_full = full; clr_drop = clr; ch_data = data;
    model_edge();
    @(posedge clk);
    #1;
    ch_done = '0; clr_drop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_done = '0; ch_data = '0; fifo_full = 1'b0; clr_drop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (fifo_wr !== 1'b0) $display("FAIL reset_wr got %b want 0", fifo_wr); else n_pass++;
    n_total++; if (fifo_din !== 64'h0) $display("FAIL reset_din got %h want 0", fifo_din); else n_pass++;
    n_total++; if (fifo_tag !== 2'd0) $display("FAIL reset_tag got %0d want 0", fifo_tag); else n_pass++;
    n_total++; if (ch_busy !== 4'h0) $display("FAIL reset_busy got %b want 0000", ch_busy); else n_pass++;
    n_total++;
    if (drop_sticky !== 4'h0) $display("FAIL reset_sticky got %b want 0000", drop_sticky);
    else n_pass++;
    n_total++; if (drop_cnt !== 4'h0) $display("FAIL reset_cnt got %0d want 0", drop_cnt); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [255:0] d;
    d = rnd_bus();
    d[128 +: 64] = 64'h0000_0000_DEAD_BEEF;
    step(4'b0100, 1'b0, 1'b0, d);
    n_total++;
    if (ch_busy !== 4'b0100 || fifo_wr !== 1'b0)
      $display("FAIL single_capture got busy=%b wr=%b want busy=0100 wr=0", ch_busy, fifo_wr);
    else n_pass++;
    step(4'b0000, 1'b0, 1'b0, rnd_bus());
    n_total++;
    if (fifo_wr !== 1'b1 || fifo_din !== 64'hDEADBEEF || fifo_tag !== 2'd2)
      $display("FAIL single_write got wr=%b din=%h tag=%0d want wr=1 din=deadbeef tag=2",
               fifo_wr, fifo_din, fifo_tag);
    else n_pass++;
    n_total++; if (ch_busy !== 4'b0000) $display("FAIL single_busy got %b want 0000", ch_busy); else n_pass++;
  endtask

  task automatic test_all_channels();
    logic [255:0] d;
    int order [2][4];
    order[0] = '{0, 1, 2, 3};
    order[1] = '{1, 2, 3, 0};
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 1) begin
        step(4'b0001, 1'b0, 1'b0, rnd_bus());
        step(4'b0000, 1'b0, 1'b0, rnd_bus());
      end
      d = rnd_bus();
      for (int c = 0; c < 4; c++) d[c*64 +: 64] = 64'hA0 + 64'(c);
      step(4'b1111, 1'b0, 1'b0, d);
      for (int k = 0; k < 4; k++) begin
        step(4'b0000, 1'b0, 1'b0, rnd_bus());
        n_total++;
        if (fifo_wr !== 1'b1 || fifo_tag !== 2'(order[rep][k]) ||
            fifo_din !== 64'hA0 + 64'(order[rep][k]))
          $display("FAIL all_ch_%0d_%0d got wr=%b tag=%0d din=%h want wr=1 tag=%0d din=%h",
                   rep, k, fifo_wr, fifo_tag, fifo_din, order[rep][k],
                   64'hA0 + 64'(order[rep][k]));
        else n_pass++;
      end
      step(4'b0000, 1'b0, 1'b0, rnd_bus());
      n_total++;
      if (fifo_wr !== 1'b0 || drop_cnt !== 4'd0)
        $display("FAIL all_ch_end_%0d got wr=%b cnt=%0d want wr=0 cnt=0", rep, fifo_wr, drop_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    step(4'b1010, 1'b1, 1'b0, rnd_bus());
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b1, 1'b0, rnd_bus());
      n_total++;
      if (fifo_wr !== 1'b0 || ch_busy !== 4'b1010)
        $display("FAIL bp_hold_%0d got wr=%b busy=%b want wr=0 busy=1010", k, fifo_wr, ch_busy);
      else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      step(4'b0000, 1'b0, 1'b0, rnd_bus());
      n_total++;
      if (fifo_wr !== 1'b1 || fifo_tag !== 2'(m_tag) || fifo_din !== m_din)
        $display("FAIL bp_resume_%0d got wr=%b tag=%0d din=%h want wr=1 tag=%0d din=%h",
                 k, fifo_wr, fifo_tag, fifo_din, m_tag, m_din);
      else n_pass++;
    end
    n_total++; if (ch_busy !== 4'b0000) $display("FAIL bp_drained got %b want 0000", ch_busy); else n_pass++;
  endtask

  task automatic test_drop();
    logic [255:0] d;
    logic [63:0]  first;
    d = rnd_bus();
    first = d[64 +: 64];
    step(4'b0010, 1'b1, 1'b0, d);
    step(4'b0010, 1'b1, 1'b0, rnd_bus());
    step(4'b0010, 1'b1, 1'b0, rnd_bus());
    n_total++;
    if (drop_cnt !== 4'd2 || drop_sticky !== 4'b0010)
      $display("FAIL drop_count got cnt=%0d sticky=%b want cnt=2 sticky=0010", drop_cnt, drop_sticky);
    else n_pass++;
    step(4'b0000, 1'b0, 1'b0, rnd_bus());
    n_total++;
    if (fifo_wr !== 1'b1 || fifo_din !== first || fifo_tag !== 2'd1)
      $display("FAIL drop_first got wr=%b din=%h tag=%0d want wr=1 din=%h tag=1",
               fifo_wr, fifo_din, fifo_tag, first);
    else n_pass++;
    step(4'b0010, 1'b1, 1'b0, rnd_bus());
    step(4'b0010, 1'b1, 1'b1, rnd_bus());
    n_total++;
    if (drop_cnt !== 4'd1 || drop_sticky !== 4'b0010)
      $display("FAIL drop_clr got cnt=%0d sticky=%b want cnt=1 sticky=0010", drop_cnt, drop_sticky);
    else n_pass++;
    step(4'b0000, 1'b0, 1'b0, rnd_bus());
  endtask

  task automatic test_saturation();
    step(4'b0001, 1'b1, 1'b1, rnd_bus());
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, 1'b1, 1'b0, rnd_bus());
      n_total++;
      if (drop_cnt !== 4'(m_cnt))
        $display("FAIL sat_step_%0d got cnt=%0d want %0d", k, drop_cnt, m_cnt);
      else n_pass++;
    end
    n_total++; if (drop_cnt !== 4'd15) $display("FAIL sat_final got %0d want 15", drop_cnt); else n_pass++;
    step(4'b0000, 1'b0, 1'b0, rnd_bus());
    step(4'b0000, 1'b0, 1'b0, rnd_bus());
  endtask

  task automatic test_reset_mid();
    step(4'b0111, 1'b1, 1'b0, rnd_bus());
    n_total++; if (ch_busy !== 4'b0111) $display("FAIL rmid_pending got %b want 0111", ch_busy); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_total++;
    if (fifo_wr !== 1'b0 || fifo_din !== 64'h0 || fifo_tag !== 2'd0 || ch_busy !== 4'h0 ||
        drop_sticky !== 4'h0 || drop_cnt !== 4'h0)
      $display("FAIL rmid_async got wr=%b din=%h tag=%0d busy=%b sticky=%b cnt=%0d want all 0",
               fifo_wr, fifo_din, fifo_tag, ch_busy, drop_sticky, drop_cnt);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(4'b0000, 1'b0, 1'b0, rnd_bus());
      n_total++; if (fifo_wr !== 1'b0) $display("FAIL rmid_idle_%0d got wr=%b want 0", k, fifo_wr); else n_pass++;
    end
    step(4'b1000, 1'b0, 1'b0, rnd_bus());
    step(4'b0000, 1'b0, 1'b0, rnd_bus());
    n_total++;
    if (fifo_wr !== 1'b1 || fifo_tag !== 2'd3 || fifo_din !== m_din)
      $display("FAIL rmid_new got wr=%b tag=%0d din=%h want wr=1 tag=3 din=%h",
               fifo_wr, fifo_tag, fifo_din, m_din);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [80:0] got, want;
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom) & 4'($urandom), ($urandom % 4) == 0, ($urandom % 32) == 0, rnd_bus());
      got  = {fifo_wr, fifo_din, fifo_tag, ch_busy, drop_sticky, drop_cnt, 2'b00};
      want = {m_wr, m_din, 2'(m_tag), m_busy(), m_sticky, 4'(m_cnt), 2'b00};
      n_total++;
      if (got !== want)
        $display("FAIL random_%0d got wr=%b din=%h tag=%0d busy=%b sticky=%b cnt=%0d want wr=%b din=%h tag=%0d busy=%b sticky=%b cnt=%0d",
                 k, fifo_wr, fifo_din, fifo_tag, ch_busy, drop_sticky, drop_cnt,
                 m_wr, m_din, m_tag, m_busy(), m_sticky, m_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_channels();
    test_backpressure();
    test_drop();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
